// File: rtl/mux_nway_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_nway_pipe
// Purpose  : Registered N-way channel select (explicit or round-robin) feeding
//            a 2-entry skid buffer with a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nway_pipe #(
    parameter int WIDTH   = 64,
    parameter int NUM_IN  = 4,
    parameter int SELW    = $clog2(NUM_IN),
    parameter int RR_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SELW-1:0]         sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_src,
    input  logic                    out_ready
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_data [2];
    logic [SELW-1:0]  r_src  [2];
    logic             r_rd;
    logic             r_wr;

    logic [SELW-1:0]  w_grant;
    logic             w_grant_vld;
    logic             w_slot_free;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_data;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic [SELW-1:0] r_ptr;
            logic [SELW-1:0] w_rr_grant;
            logic            w_rr_found;

            // Search starts one past the last accepted channel and wraps.
            always_comb begin
                logic [SELW:0] v_idx;
                logic          v_found;
                v_idx      = '0;
                v_found    = 1'b0;
                w_rr_grant = '0;
                for (int k = 1; k <= NUM_IN; k++) begin
                    v_idx = {1'b0, r_ptr} + (SELW+1)'(k);
                    if (v_idx >= (SELW+1)'(NUM_IN)) begin
                        v_idx = v_idx - (SELW+1)'(NUM_IN);
                    end
                    if (!v_found && in_valid[v_idx[SELW-1:0]]) begin
                        v_found    = 1'b1;
                        w_rr_grant = v_idx[SELW-1:0];
                    end
                end
                w_rr_found = v_found;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_ptr <= SELW'(NUM_IN - 1);
                end else if (w_push) begin
                    r_ptr <= w_grant;
                end
            end

            assign w_grant     = w_rr_grant;
            assign w_grant_vld = w_rr_found;
        end else begin : g_sel
            assign w_grant     = sel;
            assign w_grant_vld = ({1'b0, sel} < (SELW+1)'(NUM_IN));
        end
    endgenerate

    // Readiness comes from the registered fill level only, never from out_ready.
    assign w_slot_free = reset & (r_count != 2'd2);

    always_comb begin
        in_ready = '0;
        if (w_grant_vld && w_slot_free) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SELW'(i) == w_grant) begin
                w_push_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_push    = w_grant_vld & w_slot_free & in_valid[w_grant];
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_src[0]  <= '0;
            r_src[1]  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr] <= w_push_data;
                r_src[r_wr]  <= w_grant;
                r_wr         <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data = r_data[r_rd];
    assign out_src  = r_src[r_rd];

endmodule
`default_nettype wire

// File: tb/tb_mux_nway_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nway_pipe
// Purpose  : Self-checking bench: explicit 4-way, explicit 3-way, RR 4-way.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nway_pipe;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [3:0]     a_valid, a_ready;
    logic [4*W-1:0] a_data;
    logic [1:0]     a_sel, a_src;
    logic           a_ovalid, a_ordy;
    logic [W-1:0]   a_odata;

    logic [2:0]     b_valid, b_ready;
    logic [3*W-1:0] b_data;
    logic [1:0]     b_sel, b_src;
    logic           b_ovalid, b_ordy;
    logic [W-1:0]   b_odata;

    logic [3:0]     c_valid, c_ready;
    logic [4*W-1:0] c_data;
    logic [1:0]     c_sel, c_src;
    logic           c_ovalid, c_ordy;
    logic [W-1:0]   c_odata;

    mux_nway_pipe #(.WIDTH(W), .NUM_IN(4), .RR_MODE(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .sel(a_sel), .out_valid(a_ovalid),
        .out_data(a_odata), .out_src(a_src), .out_ready(a_ordy));

    mux_nway_pipe #(.WIDTH(W), .NUM_IN(3), .RR_MODE(0)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .sel(b_sel), .out_valid(b_ovalid),
        .out_data(b_odata), .out_src(b_src), .out_ready(b_ordy));

    mux_nway_pipe #(.WIDTH(W), .NUM_IN(4), .RR_MODE(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data),
        .in_ready(c_ready), .sel(c_sel), .out_valid(c_ovalid),
        .out_data(c_odata), .out_src(c_src), .out_ready(c_ordy));

    // Reference model: one FIFO of {data, source} per instance, capacity 2.
    typedef struct packed { logic [63:0] d; logic [3:0] s; } ent_t;
    ent_t qa[$], qb[$], qc[$];
    int   rr_ptr;
    int   n_err = 0;
    int   n_chk = 0;

    function automatic int n_of(int id);
        return (id == 1) ? 3 : 4;
    endfunction

    function automatic logic [3:0] vld_of(int id);
        case (id)
            0:       return a_valid;
            1:       return {1'b0, b_valid};
            default: return c_valid;
        endcase
    endfunction

    function automatic logic ordy_of(int id);
        case (id)
            0:       return a_ordy;
            1:       return b_ordy;
            default: return c_ordy;
        endcase
    endfunction

    function automatic logic [63:0] chan_data(int id, int ch);
        case (id)
            0:       return a_data[ch*W +: W];
            1:       return b_data[ch*W +: W];
            default: return c_data[ch*W +: W];
        endcase
    endfunction

    function automatic int qsize(int id);
        case (id)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic ent_t qhead(int id);
        case (id)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    function automatic int grant_of(int id);
        logic [3:0] v;
        int         s;
        if (id == 2) begin
            v = c_valid;
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (rr_ptr + k) % 4;
                if (v[i]) return i;
            end
            return -1;
        end
        s = (id == 0) ? int'(a_sel) : int'(b_sel);
        return (s < n_of(id)) ? s : -1;
    endfunction

    function automatic logic [3:0] exp_ready(int id);
        int g;
        g = grant_of(id);
        if (reset && g >= 0 && qsize(id) < 2) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] obs_ready(int id);
        case (id)
            0:       return a_ready;
            1:       return {1'b0, b_ready};
            default: return c_ready;
        endcase
    endfunction

    function automatic logic obs_valid(int id);
        case (id)
            0:       return a_ovalid;
            1:       return b_ovalid;
            default: return c_ovalid;
        endcase
    endfunction

    function automatic logic [63:0] obs_data(int id);
        case (id)
            0:       return a_odata;
            1:       return b_odata;
            default: return c_odata;
        endcase
    endfunction

    function automatic logic [3:0] obs_src(int id);
        case (id)
            0:       return {2'b00, a_src};
            1:       return {2'b00, b_src};
            default: return {2'b00, c_src};
        endcase
    endfunction

    task automatic q_push(int id, ent_t e);
        case (id)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic q_pop(int id);
        case (id)
            0:       void'(qa.pop_front());
            1:       void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        qc.delete();
        rr_ptr = 3;
    endtask

    // Advance one clock edge and apply the transfers the model predicts for it.
    task automatic tick();
        bit          pu [3];
        bit          po [3];
        int          g  [3];
        logic [63:0] d  [3];
        logic [3:0]  v;
        for (int id = 0; id < 3; id++) begin
            g[id]  = grant_of(id);
            v      = vld_of(id);
            pu[id] = reset && g[id] >= 0 && qsize(id) < 2 && v[g[id]];
            po[id] = reset && qsize(id) > 0 && ordy_of(id);
            d[id]  = (g[id] >= 0) ? chan_data(id, g[id]) : 64'd0;
        end
        @(posedge clk);
        for (int id = 0; id < 3; id++) begin
            if (po[id]) q_pop(id);
            if (pu[id]) begin
                q_push(id, ent_t'({d[id], 4'(g[id])}));
                if (id == 2) rr_ptr = g[id];
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = '0; b_valid = '0; c_valid = '0;
        a_ordy  = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) begin
            a_data[i*32 +: 32] = $urandom();
            c_data[i*32 +: 32] = $urandom();
        end
        for (int i = 0; i < 6; i++) b_data[i*32 +: 32] = $urandom();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_valid = 4'hF; a_sel = 2'd0; a_ordy = 1'b1;
        b_valid = 3'h7; b_sel = 2'd0; b_ordy = 1'b1;
        c_valid = 4'hF; c_sel = 2'd0; c_ordy = 1'b1;
        rand_data();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got=%b exp=0", a_ovalid); end
        n_chk++; if (a_odata !== 64'd0) begin n_err++; $display("FAIL reset_a_data got=%h exp=0", a_odata); end
        n_chk++; if (a_src !== 2'd0) begin n_err++; $display("FAIL reset_a_src got=%0d exp=0", a_src); end
        n_chk++; if (a_ready !== 4'h0) begin n_err++; $display("FAIL reset_a_ready got=%b exp=0000", a_ready); end
        n_chk++; if (c_ready !== 4'h0) begin n_err++; $display("FAIL reset_c_ready got=%b exp=0000", c_ready); end
        n_chk++; if (b_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid got=%b exp=0", b_ovalid); end
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_explicit();
        logic [63:0] expv [4];
        logic [3:0]  er;
        expv[0] = 64'haaa; expv[1] = 64'hbbb; expv[2] = 64'hccc; expv[3] = 64'hddd;
        a_data  = {64'hddd, 64'hccc, 64'hbbb, 64'haaa};
        a_valid = 4'hF;
        a_ordy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            er    = 4'b0001 << i;
            #1;
            n_chk++; if (a_ready !== er) begin n_err++; $display("FAIL expl_ready[%0d] got=%b exp=%b", i, a_ready, er); end
            tick();
            n_chk++; if (a_ovalid !== 1'b1) begin n_err++; $display("FAIL expl_valid[%0d] got=%b exp=1", i, a_ovalid); end
            n_chk++; if (a_odata !== expv[i]) begin n_err++; $display("FAIL expl_data[%0d] got=%h exp=%h", i, a_odata, expv[i]); end
            n_chk++; if (a_src !== 2'(i)) begin n_err++; $display("FAIL expl_src[%0d] got=%0d exp=%0d", i, a_src, i); end
        end
        a_valid = 4'h0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int   pushes;
        ent_t h;
        a_data  = {64'hddd, 64'hccc, 64'hbbb, 64'haaa};
        a_ordy  = 1'b0;
        a_sel   = 2'd2;
        a_valid = 4'hF;
        pushes  = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (a_ready[2]) pushes++;
            n_chk++; if (a_ready !== exp_ready(0)) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, a_ready, exp_ready(0)); end
            tick();
        end
        n_chk++; if (pushes != 2) begin n_err++; $display("FAIL bp_push_count got=%0d exp=2", pushes); end
        n_chk++; if (a_ready !== 4'h0) begin n_err++; $display("FAIL bp_ready_full got=%b exp=0000", a_ready); end
        n_chk++; if (a_odata !== 64'hccc) begin n_err++; $display("FAIL bp_hold_data got=%h exp=ccc", a_odata); end
        a_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (a_ready !== exp_ready(0)) begin n_err++; $display("FAIL bp_rel_ready[%0d] got=%b exp=%b", i, a_ready, exp_ready(0)); end
            n_chk++; if (a_ovalid !== (qsize(0) > 0)) begin n_err++; $display("FAIL bp_rel_valid[%0d] got=%b exp=%0d", i, a_ovalid, qsize(0) > 0); end
            if (qsize(0) > 0) begin
                h = qhead(0);
                n_chk++; if (a_odata !== h.d) begin n_err++; $display("FAIL bp_rel_data[%0d] got=%h exp=%h", i, a_odata, h.d); end
            end
            tick();
        end
        a_valid = 4'h0;
        tick(); tick();
    endtask

    task automatic test_push_pop();
        logic [63:0] w0;
        int          s;
        logic [3:0]  er;
        rand_data();
        a_ordy = 1'b0; a_sel = 2'd1; a_valid = 4'hF;
        w0 = a_data[1*W +: W];
        tick();
        for (int i = 0; i < 3; i++) begin
            s = int'($urandom_range(0, 3));
            rand_data();
            a_sel  = 2'(s);
            a_ordy = 1'b1;
            er     = 4'b0001 << s;
            #1;
            n_chk++; if (a_odata !== w0) begin n_err++; $display("FAIL pp_head[%0d] got=%h exp=%h", i, a_odata, w0); end
            n_chk++; if (a_ready !== er) begin n_err++; $display("FAIL pp_ready[%0d] got=%b exp=%b", i, a_ready, er); end
            w0 = a_data[s*W +: W];
            tick();
            n_chk++; if (a_ovalid !== 1'b1) begin n_err++; $display("FAIL pp_valid[%0d] got=%b exp=1", i, a_ovalid); end
            n_chk++; if (a_odata !== w0) begin n_err++; $display("FAIL pp_data[%0d] got=%h exp=%h", i, a_odata, w0); end
            n_chk++; if (a_src !== 2'(s)) begin n_err++; $display("FAIL pp_src[%0d] got=%0d exp=%0d", i, a_src, s); end
        end
        a_valid = 4'h0;
        tick(); tick();
    endtask

    task automatic test_invalid_sel();
        logic [63:0] e;
        rand_data();
        b_sel = 2'd3; b_valid = 3'h7; b_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (b_ready !== 3'h0) begin n_err++; $display("FAIL bad_sel_ready[%0d] got=%b exp=000", i, b_ready); end
            tick();
            n_chk++; if (b_ovalid !== 1'b0) begin n_err++; $display("FAIL bad_sel_valid[%0d] got=%b exp=0", i, b_ovalid); end
        end
        b_sel = 2'd1;
        e     = b_data[1*W +: W];
        #1;
        n_chk++; if (b_ready !== 3'b010) begin n_err++; $display("FAIL b_sel1_ready got=%b exp=010", b_ready); end
        tick();
        n_chk++; if (b_ovalid !== 1'b1) begin n_err++; $display("FAIL b_sel1_valid got=%b exp=1", b_ovalid); end
        n_chk++; if (b_odata !== e) begin n_err++; $display("FAIL b_sel1_data got=%h exp=%h", b_odata, e); end
        b_valid = 3'h0;
        tick(); tick();
    endtask

    task automatic test_rr();
        int          seq [10];
        logic [63:0] e;
        seq = '{0, 1, 3, 0, 1, 3, 0, 3, 0, 3};
        c_ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c_valid = (i < 6) ? 4'b1011 : 4'b1001;
            rand_data();
            e = c_data[seq[i]*W +: W];
            tick();
            n_chk++; if (c_src !== 2'(seq[i])) begin n_err++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, c_src, seq[i]); end
            n_chk++; if (c_odata !== e) begin n_err++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, c_odata, e); end
        end
        c_valid = 4'h0;
        tick(); tick();
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            rand_data();
            a_valid = 4'($urandom()); b_valid = 3'($urandom()); c_valid = 4'($urandom());
            a_sel   = 2'($urandom()); b_sel   = 2'($urandom()); c_sel   = 2'($urandom());
            a_ordy  = ($urandom_range(0, 3) != 0);
            b_ordy  = ($urandom_range(0, 3) != 0);
            c_ordy  = ($urandom_range(0, 3) != 0);
            #1;
            for (int id = 0; id < 3; id++) begin
                n_chk++; if (obs_ready(id) !== exp_ready(id)) begin n_err++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b exp=%b", id, n, obs_ready(id), exp_ready(id)); end
                n_chk++; if (obs_valid(id) !== (qsize(id) > 0)) begin n_err++; $display("FAIL rnd_valid dut%0d cyc%0d got=%b exp=%0d", id, n, obs_valid(id), qsize(id) > 0); end
                if (qsize(id) > 0) begin
                    h = qhead(id);
                    n_chk++; if (obs_data(id) !== h.d) begin n_err++; $display("FAIL rnd_data dut%0d cyc%0d got=%h exp=%h", id, n, obs_data(id), h.d); end
                    n_chk++; if (obs_src(id) !== h.s) begin n_err++; $display("FAIL rnd_src dut%0d cyc%0d got=%0d exp=%0d", id, n, obs_src(id), h.s); end
                end
            end
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_async_reset();
        a_ordy = 1'b0; a_sel = 2'd0; a_valid = 4'hF;
        c_ordy = 1'b0; c_valid = 4'b0100;
        tick(); tick();
        n_chk++; if (a_ovalid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid got=%b exp=1", a_ovalid); end
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL ar_a_valid_now got=%b exp=0", a_ovalid); end
        n_chk++; if (c_ovalid !== 1'b0) begin n_err++; $display("FAIL ar_c_valid_now got=%b exp=0", c_ovalid); end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_valid = 4'h0; a_ordy = 1'b1;
        c_valid = 4'hF; c_ordy = 1'b1;
        rand_data();
        #1;
        n_chk++; if (c_ready !== 4'b0001) begin n_err++; $display("FAIL ar_rr_ready got=%b exp=0001", c_ready); end
        n_chk++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL ar_no_replay got=%b exp=0", a_ovalid); end
        tick();
        n_chk++; if (c_src !== 2'd0) begin n_err++; $display("FAIL ar_rr_first got=%0d exp=0", c_src); end
        n_chk++; if (c_ovalid !== 1'b1) begin n_err++; $display("FAIL ar_rr_valid got=%b exp=1", c_ovalid); end
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_backpressure();
        test_push_pop();
        test_invalid_sel();
        test_rr();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nway_pipe.md
Name: mux_nway_pipe

Overview:
- Parametrised, registered N-way select stage: the pipelined successor of the combinational 4:1 64-bit mux.
- Selects one of NUM_IN WIDTH-bit input channels. Selection is either explicit, via `sel`, or round-robin across the valid inputs.
- Accepted words land in a 2-entry skid buffer that drives a valid/ready output.
- Used in the ARM datapath wherever several producers (forwarding paths, writeback sources) share one downstream consumer that can stall.

Parameters:
- WIDTH, 64, data width per channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SELW, $clog2(NUM_IN), width of `sel` and `out_src`.
- RR_MODE, 0: 0 = explicit select via `sel`; 1 = round-robin arbitration, `sel` ignored.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  NUM_IN  per-channel valid.
- in_data  input  NUM_IN*WIDTH  packed inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel ready; at most one bit high.
- sel  input  SELW  channel select; used only when RR_MODE=0.
- out_valid  output  1  head of skid buffer holds a word.
- out_data  output  WIDTH  head word.
- out_src  output  SELW  channel index the head word came from.
- out_ready  input  1  consumer accepts the head word this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, out_valid=0, out_data=0, out_src=0, in_ready=0.
  - RR pointer set to NUM_IN-1, so the first grant goes to channel 0.
  - Reset mid-transfer discards both buffered entries; nothing is replayed.
- Grant, RR_MODE=0:
  - grant = sel if sel < NUM_IN.
  - sel >= NUM_IN grants nothing; all in_ready=0.
- Grant, RR_MODE=1:
  - grant = first i with in_valid[i]=1, searching from ptr+1 upward and wrapping modulo NUM_IN.
  - No valid input means no grant.
  - ptr <= grant only on an accepted push; otherwise ptr holds.
- in_ready[grant] = (count < 2). All other in_ready bits are 0.
  - in_ready depends on registered count only; there is no combinational path from out_ready.
  - in_ready may be high without in_valid.
- push = in_valid[grant] & in_ready[grant]. pop = out_valid & out_ready.
- Skid buffer: 2 entries, FIFO order, each entry {data, src}.
  - push only: count+1. pop only: count-1.
  - push & pop: count unchanged; head advances and the new word enters the tail.
  - count=2: push is blocked; a pop in that cycle frees one slot for the next cycle.
  - count=0: pop is impossible (out_valid=0).
- Latency: a word pushed at edge k is visible on out_data/out_valid after edge k (1 cycle) when the buffer was empty.
- out_valid = (count != 0). out_data/out_src hold the head entry and stay stable while out_valid=1 and out_ready=0.
- Throughput: 1 word/cycle sustained when out_ready stays high.
- Data is passed bit-exact; no width change or arithmetic.
- Unselected channels' data is never stored.

Test Plan:
- Explicit select, WIDTH=64, NUM_IN=4, in_data={64'hddd,64'hccc,64'hbbb,64'haaa}, all valid, out_ready=1, sel=0,1,2,3 on consecutive cycles -> out_data aaa,bbb,ccc,ddd one cycle later, out_src 0..3, out_valid stays 1.
- Backpressure: out_ready=0, sel=2, in_valid=4'hF for 4 cycles -> exactly 2 pushes (count=2), in_ready=0 afterwards, out_data=64'hccc held. Raise out_ready -> 2 pops, then one push per cycle resumes.
- Invalid select: sel=3 with NUM_IN=3 -> in_ready=0, no push, out_valid stays 0.
- Round-robin, RR_MODE=1, in_valid=4'b1011, out_ready=1 -> grant sequence 0,1,3,0,1,3. Drop in_valid[1] mid-sequence -> 0,3,0,3.
- Simultaneous push/pop at count=1 -> count stays 1, output order preserved.
- Async reset: assert reset=0 mid-stream with count=2 -> out_valid=0 immediately, without waiting for a clock edge. After release, RR grants channel 0 first.
